vanilla_scoreboard_stall_profiler: RTL and testbench

//  Downstream consumer of the scoreboard tracker outputs (int/float per-register pending-category vectors).
//  On every ID dependency-stall cycle, attributes the stall to the category(ies) pending on the stalled

---
 rtl/vanilla_scoreboard_stall_profiler.sv | 197 +++++++++++++++++++
 tb/tb_vanilla_scoreboard_stall_profiler.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vanilla_scoreboard_stall_profiler.sv
// Vanilla core scoreboard stall profiler: attributes ID dependency stalls to pending scoreboard
// categories. Define VANILLA_SB_STALL_PROFILER_MAX_RUN_EN to add the longest-run counter (index 13).
`timescale 1ns/1ps

package vanilla_sb_profiler_pkg;

    typedef struct packed {
        logic idiv;
        logic remote_dram_load;
        logic remote_amo_dram;
        logic remote_dmem_overflow_load;
        logic remote_global_load;
        logic remote_group_load;
        logic remote_amo_group;
    } vanilla_isb_info_s;

    typedef struct packed {
        logic fdiv_fsqrt;
        logic remote_dram_load;
        logic remote_global_load;
        logic remote_group_load;
        logic remote_dmem_overflow_load;
    } vanilla_fsb_info_s;

endpackage

module vanilla_scoreboard_stall_profiler
    import vanilla_sb_profiler_pkg::*;
#(
    parameter int counter_width_p   = 32,
    parameter bit clear_on_dump_p   = 1'b1,
    parameter int reg_els_p         = 32,
    parameter int reg_addr_width_lp = 5
) (
    input  logic                                      clk_i,
    input  logic                                      reset_n_i,
    input  logic                                      stall_depend_i,
    input  logic                                      stall_all_i,
    input  logic [1:0]                                int_rs_v_i,
    input  logic [1:0][reg_addr_width_lp-1:0]         int_rs_i,
    input  logic [2:0]                                float_rs_v_i,
    input  logic [2:0][reg_addr_width_lp-1:0]         float_rs_i,
    input  vanilla_isb_info_s [reg_els_p-1:0]         int_sb_i,
    input  vanilla_fsb_info_s [reg_els_p-1:0]         float_sb_i,
    input  logic                                      dump_req_i,
    output logic                                      dump_v_o,
    input  logic                                      dump_ready_i,
    output logic [3:0]                                dump_idx_o,
    output logic [counter_width_p-1:0]                dump_data_o,
    output logic                                      busy_o
);

    localparam int         int_cats_lp  = 7;
    localparam int         fp_cats_lp   = 5;
    localparam int         base_ctrs_lp = 13;
    localparam logic [3:0] total_idx_lp = 4'd12;
`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
    localparam logic [3:0] last_idx_lp  = 4'd13;
`else
    localparam logic [3:0] last_idx_lp  = 4'd12;
`endif

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DUMP  = 2'd1,
        CLEAR = 2'd2
    } state_e;

    state_e state_r, state_n;
    logic [3:0] ptr_r;
    logic count_en;
    logic [int_cats_lp-1:0] int_hit;
    logic [fp_cats_lp-1:0]  fp_hit;
    logic [base_ctrs_lp-1:0] inc;
    logic [base_ctrs_lp-1:0][counter_width_p-1:0] ctr_r;
    logic [counter_width_p-1:0] dump_sel;

    // Bit k of the returned vector is counter index k.
    function automatic logic [int_cats_lp-1:0] isb_cats(input vanilla_isb_info_s s);
        return {s.remote_amo_group, s.remote_group_load, s.remote_global_load,
                s.remote_dmem_overflow_load, s.remote_amo_dram, s.remote_dram_load, s.idiv};
    endfunction

    function automatic logic [fp_cats_lp-1:0] fsb_cats(input vanilla_fsb_info_s s);
        return {s.remote_dmem_overflow_load, s.remote_group_load, s.remote_global_load,
                s.remote_dram_load, s.fdiv_fsqrt};
    endfunction

    assign count_en = stall_depend_i & ~stall_all_i & (state_r == IDLE);

    always_comb begin
        int_hit = '0;
        fp_hit  = '0;
        for (int unsigned i = 0; i < 2; i++) begin
            if (int_rs_v_i[i] && (int_rs_i[i] != '0))
                int_hit = int_hit | isb_cats(int_sb_i[int_rs_i[i]]);
        end
        for (int unsigned i = 0; i < 3; i++) begin
            if (float_rs_v_i[i])
                fp_hit = fp_hit | fsb_cats(float_sb_i[float_rs_i[i]]);
        end
    end

    assign inc = count_en ? {1'b1, fp_hit, int_hit} : '0;

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ctr_r <= '0;
        end else if (state_r == CLEAR) begin
            if (clear_on_dump_p)
                ctr_r <= '0;
        end else begin
            for (int unsigned k = 0; k < base_ctrs_lp; k++) begin
                if (inc[k] && (ctr_r[k] != '1))
                    ctr_r[k] <= ctr_r[k] + 1'b1;
            end
        end
    end

`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
    logic [counter_width_p-1:0] run_r, max_run_r, run_inc;

    assign run_inc = (run_r == '1) ? run_r : run_r + 1'b1;

    // Only IDLE cycles can extend or break a run; DUMP/CLEAR leave it untouched.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            run_r     <= '0;
            max_run_r <= '0;
        end else if (state_r == CLEAR) begin
            if (clear_on_dump_p) begin
                run_r     <= '0;
                max_run_r <= '0;
            end
        end else if (state_r == IDLE) begin
            if (count_en) begin
                run_r <= run_inc;
                if (run_inc > max_run_r)
                    max_run_r <= run_inc;
            end else begin
                run_r <= '0;
            end
        end
    end
`endif

    always_comb begin
        dump_sel = '0;
        if (ptr_r <= total_idx_lp)
            dump_sel = ctr_r[ptr_r];
`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
        else if (ptr_r == last_idx_lp)
            dump_sel = max_run_r;
`endif
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i)
            state_r <= IDLE;
        else
            state_r <= state_n;
    end

    always_comb begin
        state_n     = state_r;
        dump_v_o    = 1'b0;
        dump_idx_o  = '0;
        dump_data_o = '0;
        busy_o      = (state_r != IDLE);
        case (state_r)
            IDLE: begin
                if (dump_req_i)
                    state_n = DUMP;
            end
            DUMP: begin
                dump_v_o    = 1'b1;
                dump_idx_o  = ptr_r;
                dump_data_o = dump_sel;
                if (dump_ready_i && (ptr_r == last_idx_lp))
                    state_n = CLEAR;
            end
            CLEAR: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            ptr_r <= '0;
        end else if (state_r == CLEAR) begin
            ptr_r <= '0;
        end else if ((state_r == DUMP) && dump_ready_i && (ptr_r != last_idx_lp)) begin
            ptr_r <= ptr_r + 1'b1;
        end
    end

endmodule

// File: tb/tb_vanilla_scoreboard_stall_profiler.sv
// Directed self-checking bench for vanilla_scoreboard_stall_profiler (32-bit and 4-bit counter instances).
`timescale 1ns/1ps

module tb_vanilla_scoreboard_stall_profiler;
    import vanilla_sb_profiler_pkg::*;

`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
    localparam int NCTR = 14;
`else
    localparam int NCTR = 13;
`endif

    logic clk_i = 1'b0;
    logic reset_n_i;
    logic stall_depend_i, stall_all_i;
    logic [1:0] int_rs_v_i;
    logic [1:0][4:0] int_rs_i;
    logic [2:0] float_rs_v_i;
    logic [2:0][4:0] float_rs_i;
    vanilla_isb_info_s [31:0] int_sb_i;
    vanilla_fsb_info_s [31:0] float_sb_i;
    logic dump_req_i, dump_ready_i;
    logic dump_v_o, busy_o;
    logic [3:0] dump_idx_o;
    logic [31:0] dump_data_o;
    logic dump4_v_o, busy4_o;
    logic [3:0] dump4_idx_o;
    logic [3:0] dump4_data_o;

    int errors = 0;
    int checks = 0;
    logic [31:0] got [14];
    logic [31:0] got4 [14];
    logic [3:0]  got_idx [14];
    logic [31:0] exp [14];
    logic [31:0] exp4 [14];
    bit dump_ok, post_v, busy_stuck;
    int dump_cycles, hold_viol;

    always #5 clk_i = ~clk_i;

    vanilla_scoreboard_stall_profiler #(.counter_width_p(32), .clear_on_dump_p(1'b1)) dut (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
        .int_rs_v_i(int_rs_v_i), .int_rs_i(int_rs_i), .float_rs_v_i(float_rs_v_i), .float_rs_i(float_rs_i),
        .int_sb_i(int_sb_i), .float_sb_i(float_sb_i), .dump_req_i(dump_req_i), .dump_v_o(dump_v_o),
        .dump_ready_i(dump_ready_i), .dump_idx_o(dump_idx_o), .dump_data_o(dump_data_o), .busy_o(busy_o)
    );

    vanilla_scoreboard_stall_profiler #(.counter_width_p(4), .clear_on_dump_p(1'b1)) dut4 (
        .clk_i(clk_i), .reset_n_i(reset_n_i), .stall_depend_i(stall_depend_i), .stall_all_i(stall_all_i),
        .int_rs_v_i(int_rs_v_i), .int_rs_i(int_rs_i), .float_rs_v_i(float_rs_v_i), .float_rs_i(float_rs_i),
        .int_sb_i(int_sb_i), .float_sb_i(float_sb_i), .dump_req_i(dump_req_i), .dump_v_o(dump4_v_o),
        .dump_ready_i(dump_ready_i), .dump_idx_o(dump4_idx_o), .dump_data_o(dump4_data_o), .busy_o(busy4_o)
    );

    task automatic clear_inputs();
        stall_depend_i = 1'b0; stall_all_i = 1'b0;
        int_rs_v_i = '0; int_rs_i = '0; float_rs_v_i = '0; float_rs_i = '0;
        int_sb_i = '0; float_sb_i = '0;
        exp = '{default: '0};
        exp4 = '{default: '0};
    endtask

    // Called at posedge+1; each cycle's stall value is held across exactly one posedge.
    task automatic stall_cycles(input int n, input logic [31:0] all_mask);
        for (int i = 0; i < n; i++) begin
            stall_depend_i = 1'b1;
            stall_all_i = all_mask[i];
            @(posedge clk_i); #1;
        end
        stall_depend_i = 1'b0;
        stall_all_i = 1'b0;
    endtask

    task automatic do_dump(input bit toggle_ready, input bit hold_req);
        int n, cyc;
        bit held;
        logic [3:0] h_idx;
        logic [31:0] h_data;
        n = 0; cyc = 0; held = 1'b0; hold_viol = 0; h_idx = '0; h_data = '0;
        dump_req_i = 1'b1;
        dump_ready_i = 1'b1;
        @(posedge clk_i); #1;
        if (!hold_req) dump_req_i = 1'b0;
        while (n < NCTR && cyc < 100) begin
            @(negedge clk_i);
            if (held && (dump_idx_o !== h_idx || dump_data_o !== h_data)) hold_viol++;
            held = 1'b0;
            if (dump_v_o && dump_ready_i) begin
                got_idx[n] = dump_idx_o;
                got[n] = dump_data_o;
                got4[n] = {28'b0, dump4_data_o};
                n++;
                if (n == NCTR) begin
                    stall_depend_i = 1'b0;
                    dump_req_i = 1'b0;
                end
            end else if (dump_v_o) begin
                held = 1'b1;
                h_idx = dump_idx_o;
                h_data = dump_data_o;
            end
            cyc++;
            @(posedge clk_i); #1;
            if (toggle_ready) dump_ready_i = ~dump_ready_i;
        end
        dump_ok = (n == NCTR);
        dump_cycles = cyc;
        stall_depend_i = 1'b0;
        dump_req_i = 1'b0;
        dump_ready_i = 1'b1;
        @(negedge clk_i);
        post_v = dump_v_o;
        cyc = 0;
        while (busy_o && cyc < 10) begin
            @(negedge clk_i);
            cyc++;
        end
        busy_stuck = busy_o;
        @(posedge clk_i); #1;
    endtask

    task automatic test_reset();
        checks++; if (dump_v_o !== 1'b0) begin errors++; $display("FAIL reset_v: got %b expected 0", dump_v_o); end
        checks++; if (dump_idx_o !== 4'd0) begin errors++; $display("FAIL reset_idx: got %0d expected 0", dump_idx_o); end
        checks++; if (dump_data_o !== 32'd0) begin errors++; $display("FAIL reset_data: got %0d expected 0", dump_data_o); end
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy_o); end
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL reset_dump_timeout: got %0d cycles without %0d entries", dump_cycles, NCTR); end
        checks++; if (dump_cycles !== NCTR) begin errors++; $display("FAIL reset_dump_cycles: got %0d expected %0d", dump_cycles, NCTR); end
        checks++; if (post_v !== 1'b0) begin errors++; $display("FAIL reset_dump_extra_entry: got v=%b expected 0", post_v); end
        checks++; if (busy_stuck !== 1'b0) begin errors++; $display("FAIL reset_dump_busy: got %b expected 0", busy_stuck); end
        for (int k = 0; k < NCTR; k++) begin
            checks++;
            if (got_idx[k] !== 4'(k) || got[k] !== 32'd0) begin
                errors++; $display("FAIL reset_dump entry%0d: got idx=%0d data=%0d expected idx=%0d data=0", k, got_idx[k], got[k], k);
            end
        end
    endtask

    task automatic test_int_attr();
        clear_inputs();
        int_sb_i[5].remote_dram_load = 1'b1;
        int_rs_v_i = 2'b01; int_rs_i[0] = 5'd5;
        stall_cycles(10, 32'd0);
        exp[1] = 32'd10; exp[12] = 32'd10; exp[13] = 32'd10;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL int_attr_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL int_attr idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_stall_all();
        clear_inputs();
        int_sb_i[5].remote_dram_load = 1'b1;
        int_rs_v_i = 2'b01; int_rs_i[0] = 5'd5;
        stall_cycles(10, 32'b0100100100);
        exp[1] = 32'd7; exp[12] = 32'd7; exp[13] = 32'd2;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL stall_all_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL stall_all idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_zero_reg();
        clear_inputs();
        int_sb_i[0] = '1;
        int_rs_v_i = 2'b11; int_rs_i[0] = 5'd0; int_rs_i[1] = 5'd0;
        float_sb_i[0].remote_dram_load = 1'b1;
        float_rs_v_i = 3'b001; float_rs_i[0] = 5'd0;
        stall_cycles(4, 32'd0);
        exp[8] = 32'd4; exp[12] = 32'd4; exp[13] = 32'd4;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL zero_reg_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL zero_reg idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_float_attr();
        clear_inputs();
        float_sb_i[3].fdiv_fsqrt = 1'b1;
        float_sb_i[4].remote_group_load = 1'b1;
        float_rs_v_i = 3'b011; float_rs_i[0] = 5'd4; float_rs_i[1] = 5'd3;
        stall_cycles(4, 32'd0);
        exp[7] = 32'd4; exp[10] = 32'd4; exp[12] = 32'd4; exp[13] = 32'd4;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL float_attr_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL float_attr idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_multi_hit();
        clear_inputs();
        int_sb_i[9].idiv = 1'b1;
        int_sb_i[9].remote_global_load = 1'b1;
        int_rs_v_i = 2'b11; int_rs_i[0] = 5'd9; int_rs_i[1] = 5'd9;
        float_sb_i[2].remote_dmem_overflow_load = 1'b1;
        float_sb_i[6].fdiv_fsqrt = 1'b1;
        float_rs_v_i = 3'b100; float_rs_i[2] = 5'd2; float_rs_i[0] = 5'd6;
        stall_cycles(3, 32'd0);
        repeat (2) @(posedge clk_i);
        #1;
        exp[0] = 32'd3; exp[4] = 32'd3; exp[11] = 32'd3; exp[12] = 32'd3; exp[13] = 32'd3;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL multi_hit_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL multi_hit idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask

    task automatic test_saturation();
        clear_inputs();
        int_sb_i[7].idiv = 1'b1;
        int_rs_v_i = 2'b10; int_rs_i[1] = 5'd7;
        stall_cycles(20, 32'd0);
        exp[0] = 32'd20; exp[12] = 32'd20; exp[13] = 32'd20;
        exp4[0] = 32'd15; exp4[12] = 32'd15; exp4[13] = 32'd15;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL saturation_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL saturation_w32 idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
            checks++; if (got4[k] !== exp4[k]) begin errors++; $display("FAIL saturation_w4 idx%0d: got %0d expected %0d", k, got4[k], exp4[k]); end
        end
    endtask

    task automatic test_back_to_back();
        clear_inputs();
        int_sb_i[12].remote_amo_group = 1'b1;
        int_rs_v_i = 2'b01; int_rs_i[0] = 5'd12;
        stall_cycles(5, 32'd0);
        // Stall stays high through the request cycle (counted) and the whole dump (not counted).
        stall_depend_i = 1'b1;
        exp[6] = 32'd6; exp[12] = 32'd6; exp[13] = 32'd6;
        do_dump(1'b1, 1'b1);
        checks++; if (!dump_ok) begin errors++; $display("FAIL backpressure_timeout: got %0d cycles", dump_cycles); end
        checks++; if (dump_cycles !== 2*NCTR-1) begin errors++; $display("FAIL backpressure_cycles: got %0d expected %0d", dump_cycles, 2*NCTR-1); end
        checks++; if (hold_viol !== 0) begin errors++; $display("FAIL backpressure_hold: got %0d changes expected 0", hold_viol); end
        checks++; if (post_v !== 1'b0 || busy_stuck !== 1'b0) begin errors++; $display("FAIL backpressure_end: got v=%b busy=%b expected 0 0", post_v, busy_stuck); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got_idx[k] !== 4'(k) || got[k] !== exp[k]) begin
                errors++; $display("FAIL backpressure idx%0d: got idx=%0d data=%0d expected idx=%0d data=%0d", k, got_idx[k], got[k], k, exp[k]);
            end
        end
        exp = '{default: '0};
        do_dump(1'b0, 1'b0);
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL cleared_after_dump idx%0d: got %0d expected 0", k, got[k]); end
        end
    endtask

    task automatic test_reset_mid_dump();
        clear_inputs();
        stall_cycles(3, 32'd0);
        dump_req_i = 1'b1; dump_ready_i = 1'b1;
        @(posedge clk_i); #1;
        dump_req_i = 1'b0;
        repeat (12) @(posedge clk_i);
        #1;
        checks++; if (dump_v_o !== 1'b1 || dump_idx_o !== 4'd12 || dump_data_o !== 32'd3) begin
            errors++; $display("FAIL mid_dump_entry: got v=%b idx=%0d data=%0d expected 1 12 3", dump_v_o, dump_idx_o, dump_data_o);
        end
        #2 reset_n_i = 1'b0;
        #1;
        checks++; if (dump_v_o !== 1'b0 || dump_idx_o !== 4'd0 || dump_data_o !== 32'd0 || busy_o !== 1'b0) begin
            errors++; $display("FAIL async_reset: got v=%b idx=%0d data=%0d busy=%b expected all 0", dump_v_o, dump_idx_o, dump_data_o, busy_o);
        end
        @(posedge clk_i); #1;
        reset_n_i = 1'b1;
        @(posedge clk_i); #1;
        checks++; if (busy_o !== 1'b0) begin errors++; $display("FAIL post_reset_busy: got %b expected 0", busy_o); end
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL post_reset_dump_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== 32'd0) begin errors++; $display("FAIL post_reset_dump idx%0d: got %0d expected 0", k, got[k]); end
        end
    endtask

`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
    task automatic test_max_run();
        clear_inputs();
        stall_cycles(3, 32'd0);
        @(posedge clk_i); #1;
        stall_cycles(7, 32'd0);
        exp[12] = 32'd10; exp[13] = 32'd7;
        do_dump(1'b0, 1'b0);
        checks++; if (!dump_ok) begin errors++; $display("FAIL max_run_timeout: got %0d cycles", dump_cycles); end
        for (int k = 0; k < NCTR; k++) begin
            checks++; if (got[k] !== exp[k]) begin errors++; $display("FAIL max_run idx%0d: got %0d expected %0d", k, got[k], exp[k]); end
        end
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_n_i = 1'b0;
        dump_req_i = 1'b0;
        dump_ready_i = 1'b1;
        clear_inputs();
        repeat (3) @(posedge clk_i);
        #1;
        test_reset();
        test_int_attr();
        test_stall_all();
        test_zero_reg();
        test_float_attr();
        test_multi_hit();
        test_saturation();
        test_back_to_back();
        test_reset_mid_dump();
`ifdef VANILLA_SB_STALL_PROFILER_MAX_RUN_EN
        test_max_run();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
